// File: rtl/delay_sweep_ctrl.sv
// Sweeps delay-line taps over a configured range, measures sample_in at each tap and
// reports one record per tap plus the first tap where the majority value flips.
module delay_sweep_ctrl #(
  parameter int unsigned DW      = 9,
  parameter int unsigned NW      = 16,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_first,
  input  logic [DW-1:0] cfg_last,
  input  logic [DW-1:0] cfg_step,
  input  logic [NW-1:0] cfg_samples,
  output logic          dly_change,
  output logic          dly_read,
  output logic [DW-1:0] dly_value,
  input  logic          dly_done,
  input  logic [DW-1:0] dly_cntval,
  input  logic          sample_in,
  output logic          busy,
  output logic          res_valid,
  output logic [DW-1:0] res_tap,
  output logic [DW-1:0] res_cntval,
  output logic [NW-1:0] res_ones,
  output logic [NW-1:0] res_toggles,
  output logic          sweep_done,
  output logic          sweep_err,
  output logic          edge_found,
  output logic [DW-1:0] edge_tap
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (TW > NW) ? TW : NW;

  typedef enum logic [3:0] {
    StIdle, StLoad, StWaitLoad, StSettle, StSample,
    StRead, StWaitRead, StReport, StNext, StFinish
  } state_e;

  state_e        state_q;
  logic [DW-1:0] last_q, step_q, tap_q;
  logic [NW-1:0] nsamp_q, ones_q, tog_q;
  logic [CW-1:0] cnt_q;
  logic          prev_q, have_prev_q, prev_maj_q;

  logic [DW:0]   nt;
  logic          maj;

  always_comb begin
    nt  = {1'b0, tap_q} + {1'b0, step_q};
    maj = ({ones_q, 1'b0} >= {1'b0, nsamp_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= '0;
      step_q      <= '0;
      tap_q       <= '0;
      nsamp_q     <= '0;
      ones_q      <= '0;
      tog_q       <= '0;
      cnt_q       <= '0;
      prev_q      <= 1'b0;
      have_prev_q <= 1'b0;
      prev_maj_q  <= 1'b0;
      dly_change  <= 1'b0;
      dly_read    <= 1'b0;
      dly_value   <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_tap     <= '0;
      res_cntval  <= '0;
      res_ones    <= '0;
      res_toggles <= '0;
      sweep_done  <= 1'b0;
      sweep_err   <= 1'b0;
      edge_found  <= 1'b0;
      edge_tap    <= '0;
    end else begin
      dly_change <= 1'b0;
      dly_read   <= 1'b0;
      res_valid  <= 1'b0;
      sweep_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            last_q      <= cfg_last;
            step_q      <= (cfg_step == '0) ? DW'(1) : cfg_step;
            nsamp_q     <= (cfg_samples == '0) ? NW'(1) : cfg_samples;
            tap_q       <= cfg_first;
            have_prev_q <= 1'b0;
            sweep_err   <= 1'b0;
            edge_found  <= 1'b0;
            edge_tap    <= '0;
            busy        <= 1'b1;
            if (cfg_first > cfg_last) begin
              // NEXT always terminates here since tap > last; gives the extra busy cycle
              sweep_err <= 1'b1;
              state_q   <= StNext;
            end else if (abort) begin
              sweep_err  <= 1'b1;
              busy       <= 1'b0;
              sweep_done <= 1'b1;
              state_q    <= StFinish;
            end else begin
              dly_change <= 1'b1;
              dly_value  <= cfg_first;
              state_q    <= StLoad;
            end
          end
        end
        StLoad: begin
          cnt_q   <= '0;
          state_q <= StWaitLoad;
        end
        StWaitLoad: begin
          if (dly_done) begin
            cnt_q   <= '0;
            state_q <= StSettle;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            sweep_err  <= 1'b1;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state_q    <= StFinish;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            ones_q  <= '0;
            tog_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSample: begin
          ones_q <= ones_q + NW'(sample_in);
          // first sample has no predecessor, so it never counts as a transition
          tog_q  <= tog_q + NW'((cnt_q != '0) && (sample_in != prev_q));
          prev_q <= sample_in;
          if (cnt_q == CW'(nsamp_q - NW'(1))) begin
            dly_read <= 1'b1;
            state_q  <= StRead;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRead: begin
          cnt_q   <= '0;
          state_q <= StWaitRead;
        end
        StWaitRead: begin
          if (dly_done) begin
            res_valid   <= 1'b1;
            res_tap     <= tap_q;
            res_cntval  <= dly_cntval;
            res_ones    <= ones_q;
            res_toggles <= tog_q;
            have_prev_q <= 1'b1;
            prev_maj_q  <= maj;
            if (have_prev_q && (maj != prev_maj_q) && !edge_found) begin
              edge_found <= 1'b1;
              edge_tap   <= tap_q;
            end
            state_q <= StReport;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            sweep_err  <= 1'b1;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state_q    <= StFinish;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReport: begin
          if (abort) begin
            sweep_err  <= 1'b1;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state_q    <= StFinish;
          end else begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (nt[DW] || (nt > {1'b0, last_q})) begin
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state_q    <= StFinish;
          end else if (abort) begin
            sweep_err  <= 1'b1;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state_q    <= StFinish;
          end else begin
            tap_q      <= nt[DW-1:0];
            dly_value  <= nt[DW-1:0];
            dly_change <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed bench for delay_sweep_ctrl with a behavioural delay-line model.
module tb_delay_sweep_ctrl;
  localparam int DW = 9;
  localparam int NW = 16;
  localparam int SETTLE = 16;
  localparam int TIMEOUT = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] cfg_first = '0, cfg_last = '0, cfg_step = '0;
  logic [NW-1:0] cfg_samples = '0;
  logic          dly_change, dly_read, dly_done;
  logic [DW-1:0] dly_value, dly_cntval;
  logic          sample_in;
  logic          busy, res_valid, sweep_done, sweep_err, edge_found;
  logic [DW-1:0] res_tap, res_cntval, edge_tap;
  logic [NW-1:0] res_ones, res_toggles;

  delay_sweep_ctrl #(.DW(DW), .NW(NW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_step(cfg_step),
    .cfg_samples(cfg_samples),
    .dly_change(dly_change), .dly_read(dly_read), .dly_value(dly_value),
    .dly_done(dly_done), .dly_cntval(dly_cntval), .sample_in(sample_in),
    .busy(busy), .res_valid(res_valid), .res_tap(res_tap), .res_cntval(res_cntval),
    .res_ones(res_ones), .res_toggles(res_toggles), .sweep_done(sweep_done),
    .sweep_err(sweep_err), .edge_found(edge_found), .edge_tap(edge_tap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Delay-line model: done strobe 'lat' cycles after each request.
  int            lat = 3;
  bit            dly_en = 1'b1;
  int            m_cnt;
  logic          m_read;
  logic [DW-1:0] model_tap;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_done <= 1'b0; m_cnt <= 0; m_read <= 1'b0; model_tap <= '0;
    end else begin
      dly_done <= 1'b0;
      if (dly_en && (dly_change || dly_read)) begin
        if (dly_change) model_tap <= dly_value;
        m_read <= dly_read;
        if (lat == 1) dly_done <= 1'b1;
        else m_cnt <= lat - 1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) dly_done <= 1'b1;
      end
    end
  end
  assign dly_cntval = model_tap + 9'd3;

  // sample_in source: 0 constant, 1 step at tap 30, 2 toggles every cycle
  int   smode = 0;
  logic sconst = 1'b1;
  logic tgl = 1'b0;
  always @(posedge clk) tgl <= ~tgl;
  assign sample_in = (smode == 0) ? sconst : (smode == 1) ? (model_tap >= 9'd30) : tgl;

  // Monitor
  int q_tap[$], q_ones[$], q_tog[$], q_cv[$];
  int chg_cnt, first_chg_cyc, last_chg_cyc, both_bad, rd_done_cyc, rv_lat_bad;
  int first_rv_cyc, done_cnt, done_cyc, done_busy;
  int t0, busy_c1, chg_c1;
  always @(negedge clk) begin
    if (dly_change) begin
      chg_cnt++;
      if (chg_cnt == 1) first_chg_cyc = cyc;
      last_chg_cyc = cyc;
    end
    if (dly_change && dly_read) both_bad++;
    if (dly_done && m_read) rd_done_cyc = cyc;
    if (res_valid) begin
      q_tap.push_back(int'(res_tap)); q_ones.push_back(int'(res_ones));
      q_tog.push_back(int'(res_toggles)); q_cv.push_back(int'(res_cntval));
      if (q_tap.size() == 1) first_rv_cyc = cyc;
      if (cyc != rd_done_cyc + 1) rv_lat_bad++;
    end
    if (sweep_done) begin
      done_cnt++; done_cyc = cyc; done_busy = int'(busy);
    end
  end

  int errors = 0;
  int checks = 0;
  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    q_tap.delete(); q_ones.delete(); q_tog.delete(); q_cv.delete();
    chg_cnt = 0; first_chg_cyc = -1; last_chg_cyc = -1; rd_done_cyc = -10;
    first_rv_cyc = -1; done_cnt = 0; done_cyc = -1; done_busy = -1;
  endtask

  task automatic start_sweep(input int first, input int last, input int step, input int ns);
    @(negedge clk);
    clear_stats();
    cfg_first = DW'(first); cfg_last = DW'(last); cfg_step = DW'(step);
    cfg_samples = NW'(ns);
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    busy_c1 = int'(busy); chg_c1 = int'(dly_change);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); n++;
    end
    if (done_cnt == 0) check_eq({tag, "_done_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clear_stats();
    both_bad = 0; rv_lat_bad = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_outs", int'({dly_change, dly_read, res_valid, sweep_done, sweep_err,
                                edge_found}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sweep, 18-cycle latency
    lat = 18; smode = 0; sconst = 1'b1;
    start_sweep(0, 20, 10, 8);
    check_eq("basic_busy_c1", busy_c1, 1);
    check_eq("basic_chg_c1", chg_c1, 1);
    wait_done("basic", 2000);
    check_eq("basic_nrec", q_tap.size(), 3);
    check_eq("basic_tap0", q_tap[0], 0);
    check_eq("basic_tap1", q_tap[1], 10);
    check_eq("basic_tap2", q_tap[2], 20);
    check_eq("basic_ones0", q_ones[0], 8);
    check_eq("basic_ones2", q_ones[2], 8);
    check_eq("basic_tog", q_tog[0] + q_tog[1] + q_tog[2], 0);
    check_eq("basic_cv1", q_cv[1], 13);
    check_eq("basic_rv_cyc", first_rv_cyc - t0, 63);
    check_eq("basic_done_cyc", done_cyc - t0, 193);
    check_eq("basic_done_busy", done_busy, 0);
    check_eq("basic_edge", int'(edge_found), 0);
    check_eq("basic_err", int'(sweep_err), 0);
    check_eq("basic_busy_after", int'(busy), 0);

    // Edge detect at tap 30
    lat = 3; smode = 1;
    start_sweep(0, 60, 10, 100);
    wait_done("edge", 5000);
    check_eq("edge_nrec", q_tap.size(), 7);
    check_eq("edge_found", int'(edge_found), 1);
    check_eq("edge_tap", int'(edge_tap), 30);
    check_eq("edge_ones20", q_ones[2], 0);
    check_eq("edge_ones30", q_ones[3], 100);

    // Bad config
    start_sweep(100, 50, 1, 4);
    wait_done("bad", 50);
    check_eq("bad_done_cyc", done_cyc - t0, 2);
    check_eq("bad_busy_c1", busy_c1, 1);
    check_eq("bad_err", int'(sweep_err), 1);
    check_eq("bad_nrec", q_tap.size(), 0);
    check_eq("bad_nchg", chg_cnt, 0);
    check_eq("bad_edge_clr", int'(edge_found), 0);

    // step=0 and samples=0 both behave as 1
    smode = 0; sconst = 1'b1;
    start_sweep(5, 5, 0, 0);
    wait_done("zero", 500);
    check_eq("zero_nrec", q_tap.size(), 1);
    check_eq("zero_ones", q_ones[0], 1);
    check_eq("zero_tog", q_tog[0], 0);
    check_eq("zero_err_clr", int'(sweep_err), 0);

    // Overflow end with a toggling input
    smode = 2;
    start_sweep(500, 511, 8, 6);
    wait_done("ovf", 1000);
    check_eq("ovf_nrec", q_tap.size(), 2);
    check_eq("ovf_tap0", q_tap[0], 500);
    check_eq("ovf_tap1", q_tap[1], 508);
    check_eq("ovf_ones", q_ones[1], 3);
    check_eq("ovf_tog", q_tog[0], 5);
    check_eq("ovf_cv1", q_cv[1], 511);
    check_eq("ovf_edge", int'(edge_found), 0);

    // Timeout: downstream never answers
    smode = 0; dly_en = 1'b0;
    start_sweep(0, 10, 1, 4);
    wait_done("tmo", 3000);
    check_eq("tmo_done_cyc", done_cyc - last_chg_cyc, TIMEOUT + 2);
    check_eq("tmo_err", int'(sweep_err), 1);
    check_eq("tmo_nrec", q_tap.size(), 0);
    dly_en = 1'b1;

    // Abort during SAMPLE of tap 0
    lat = 3;
    start_sweep(0, 40, 10, 8);
    while (cyc < t0 + 24) @(negedge clk);
    abort = 1'b1;
    wait_done("abort", 500);
    abort = 1'b0;
    check_eq("abort_nrec", q_tap.size(), 1);
    check_eq("abort_tap", q_tap[0], 0);
    check_eq("abort_nchg", chg_cnt, 1);
    check_eq("abort_err", int'(sweep_err), 1);
    check_eq("abort_busy", int'(busy), 0);

    // Reset in WAIT_LOAD
    lat = 18;
    start_sweep(40, 80, 10, 8);
    while (cyc < t0 + 10) @(negedge clk);
    check_eq("rstm_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_eq("rstm_busy", int'(busy), 0);
    check_eq("rstm_value", int'(dly_value), 0);
    check_eq("rstm_outs", int'({dly_change, dly_read, res_valid, sweep_done, sweep_err,
                                edge_found, res_tap, edge_tap}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("rstm_no_done", done_cnt, 0);

    check_eq("never_both_req", both_bad, 0);
    check_eq("rv_after_read_done", rv_lat_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
